cond_pipe_ctrl: RTL
===================

COND_PIPE_CTRL -- requirements
Module: cond_pipe_ctrl

Interface
REQ-001 Parameter ALUCTRL_W, default 2: width of the ALU control field.
REQ-002 Parameter MEM_STAGES, default 1, legal 1..4: number of memory-stage registers between E and W.
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Ports RegWriteD, MemWriteD, MemtoRegD, PCSrcD, BranchD, ALUSrcD, input, 1 each: decoded control from decode stage.
REQ-006 Ports ALUControlD (ALUCTRL_W), FlagWriteD (2), CondD (4), input: decoded ALU op, flag-write mask {NZ,CV}, condition field.
REQ-007 Ports StallE, FlushE, input, 1 each: hold or clear the E control register.
REQ-008 Port ALUFlags, input, 4: {N,Z,C,V} from the ALU in E.
REQ-009 Ports ALUSrcE, ALUControlE (ALUCTRL_W), MemtoRegE, PCSrcE, output: E-register contents, unconditioned.
REQ-010 Ports CondExE, BranchTakenE, output, 1 each: condition pass; BranchE AND CondExE.
REQ-011 Ports MemWriteM, output, 1: conditioned write from first M stage; RegWriteM, PCSrcM, MemtoRegM, output, 1: last M stage.
REQ-012 Ports RegWriteW, MemtoRegW, PCSrcW, output, 1 each: W-register contents.
REQ-013 Port Flags, output, 4: current architectural flag register.

Function
REQ-014 E register SHALL load all D fields when StallE=0 and FlushE=0; hold when StallE=1 and FlushE=0.
REQ-015 FlushE=1 SHALL clear every E field to 0 at the next edge, overriding StallE.
REQ-016 CondExE SHALL be combinational from CondE and the Flags register (no same-cycle ALUFlags bypass), full 4-bit code set: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; code 4'b1111 SHALL evaluate as 1.
REQ-017 At an edge with StallE=0 and CondExE=1: FlagWriteE[1]=1 loads Flags[3:2] from ALUFlags[3:2]; FlagWriteE[0]=1 loads Flags[1:0] from ALUFlags[1:0]; otherwise Flags holds.
REQ-018 RegWrite, MemWrite, PCSrc entering M1 SHALL be ANDed with CondExE; MemtoReg SHALL pass unconditioned.
REQ-019 StallE=1 SHALL inject a bubble (all zeros) into M1 and SHALL block flag updates, so a held instruction commits exactly once.
REQ-020 M stages SHALL form a shift chain M1..M_MEM_STAGES advancing every cycle, never stalled; W SHALL load from the last M stage every cycle.
REQ-021 Latency D->E 1 cycle, E->M1 1, E->W MEM_STAGES+1 cycles; MEM_STAGES=1 makes M1 both first and last stage.
REQ-022 Simultaneous FlushE and a conditioned instruction in E: the E instruction SHALL still advance to M1 and update flags this edge; flush affects only the incoming D instruction.

Reset
REQ-023 reset=1 SHALL clear E, all M stages, W and Flags to 0 at the next edge; all outputs read 0 afterwards except CondExE (evaluates CondE=0, EQ, with Z=0 -> 0).
REQ-024 reset SHALL take priority over StallE and FlushE; reset mid-operation discards every in-flight instruction.

Structure
REQ-025 Package cond_pipe_pkg SHALL hold the 16 condition-code constants, flag bit indices N=3,Z=2,C=1,V=0, and MEM_STAGES bounds.
REQ-026 Condition evaluation SHALL be one combinational sub-module, cond_check (CondE, Flags -> CondExE).
REQ-027 An out-of-range MEM_STAGES SHALL fail elaboration.

Verification
REQ-028 Reset: 3 cycles reset=1 with D fields all 1 -> all pipeline outputs and Flags = 0.
REQ-029 Flags: ADDS (FlagWriteD=2'b11, CondD=AL), ALUFlags=4'b0100 -> Flags=4'b0100 one edge after E; next CondD=EQ RegWriteD=1 -> RegWriteW=1 after MEM_STAGES+1 cycles.
REQ-030 Cond fail: Flags=0, CondD=EQ, RegWriteD=MemWriteD=BranchD=1 -> BranchTakenE=0, MemWriteM=0, RegWriteW=0, Flags unchanged.
REQ-031 Stall: instruction with FlagWriteD=2'b01 held 2 cycles by StallE -> M1 zero for 2 cycles, single entry into M1, Flags written once.
REQ-032 Flush+stall: FlushE=1 StallE=1 with RegWriteD=1 -> E fields 0, no RegWriteW 1+MEM_STAGES+1 cycles later.
REQ-033 Depth sweep MEM_STAGES=1,2,4: one RegWrite instruction -> RegWriteM at E+MEM_STAGES, RegWriteW at E+MEM_STAGES+1.

Source files
------------

// File: rtl/cond_pipe_pkg.sv
// Shared constants and types for the conditional-execution pipeline controller.
// Covers condition codes, flag bit positions and the legal memory-stage depth range.
package cond_pipe_pkg;

  localparam int unsigned MemStagesMin = 1;
  localparam int unsigned MemStagesMax = 4;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  // One memory-stage slot; the conditioned bits are already ANDed with CondExE.
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic pc_src;
    logic mem_to_reg;
  } mstage_t;

  localparam int unsigned MStageW = $bits(mstage_t);

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator against the architectural flag register.
module cond_check
  import cond_pipe_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] Flags,
  output logic       CondExE
);

  logic w_n, w_z, w_c, w_v, w_ge;

  assign w_n  = Flags[FlagN];
  assign w_z  = Flags[FlagZ];
  assign w_c  = Flags[FlagC];
  assign w_v  = Flags[FlagV];
  assign w_ge = (w_n == w_v);

  always_comb begin
    CondExE = 1'b1;
    case (CondE)
      CondEq:  CondExE = w_z;
      CondNe:  CondExE = ~w_z;
      CondCs:  CondExE = w_c;
      CondCc:  CondExE = ~w_c;
      CondMi:  CondExE = w_n;
      CondPl:  CondExE = ~w_n;
      CondVs:  CondExE = w_v;
      CondVc:  CondExE = ~w_v;
      CondHi:  CondExE = w_c & ~w_z;
      CondLs:  CondExE = ~w_c | w_z;
      CondGe:  CondExE = w_ge;
      CondLt:  CondExE = ~w_ge;
      CondGt:  CondExE = ~w_z & w_ge;
      CondLe:  CondExE = w_z | ~w_ge;
      CondAl:  CondExE = 1'b1;
      default: CondExE = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_pipe_ctrl.sv
// Control-path pipeline E -> M1..Mn -> W with conditional execution and flag register.
// Stalls bubble M1 and freeze flags; flushes clear only the incoming E contents.
module cond_pipe_ctrl
  import cond_pipe_pkg::*;
#(
  parameter int unsigned ALUCTRL_W  = 2,
  parameter int unsigned MEM_STAGES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RegWriteD,
  input  logic                 MemWriteD,
  input  logic                 MemtoRegD,
  input  logic                 PCSrcD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [1:0]           FlagWriteD,
  input  logic [3:0]           CondD,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic [3:0]           ALUFlags,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 MemtoRegE,
  output logic                 PCSrcE,
  output logic                 CondExE,
  output logic                 BranchTakenE,
  output logic                 MemWriteM,
  output logic                 RegWriteM,
  output logic                 PCSrcM,
  output logic                 MemtoRegM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic                 PCSrcW,
  output logic [3:0]           Flags
);

  if (MEM_STAGES < MemStagesMin || MEM_STAGES > MemStagesMax) begin : g_bad_mem_stages
    $error("cond_pipe_ctrl: MEM_STAGES must be in 1..4");
  end

  localparam int unsigned ChainW = MStageW * MEM_STAGES;

  logic                 r_reg_write_e, r_mem_write_e, r_mem_to_reg_e;
  logic                 r_pc_src_e, r_branch_e, r_alu_src_e;
  logic [ALUCTRL_W-1:0] r_alu_control_e;
  logic [1:0]           r_flag_write_e;
  logic [3:0]           r_cond_e;
  logic [3:0]           r_flags;
  logic [3:0]           w_flags_d;
  logic                 w_cond_ex;
  mstage_t              w_m1_in, w_m_first, w_m_last;
  logic [ChainW-1:0]    r_m_chain;
  logic [ChainW+MStageW-1:0] w_shift;
  logic                 r_reg_write_w, r_mem_to_reg_w, r_pc_src_w;

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      r_reg_write_e   <= 1'b0;
      r_mem_write_e   <= 1'b0;
      r_mem_to_reg_e  <= 1'b0;
      r_pc_src_e      <= 1'b0;
      r_branch_e      <= 1'b0;
      r_alu_src_e     <= 1'b0;
      r_alu_control_e <= '0;
      r_flag_write_e  <= 2'b00;
      r_cond_e        <= 4'b0000;
    end else if (!StallE) begin
      r_reg_write_e   <= RegWriteD;
      r_mem_write_e   <= MemWriteD;
      r_mem_to_reg_e  <= MemtoRegD;
      r_pc_src_e      <= PCSrcD;
      r_branch_e      <= BranchD;
      r_alu_src_e     <= ALUSrcD;
      r_alu_control_e <= ALUControlD;
      r_flag_write_e  <= FlagWriteD;
      r_cond_e        <= CondD;
    end
  end

  cond_check u_cond_check (
    .CondE   (r_cond_e),
    .Flags   (r_flags),
    .CondExE (w_cond_ex)
  );

  always_comb begin
    w_flags_d = r_flags;
    if (!StallE && w_cond_ex) begin
      if (r_flag_write_e[1]) w_flags_d[FlagN:FlagZ] = ALUFlags[FlagN:FlagZ];
      if (r_flag_write_e[0]) w_flags_d[FlagC:FlagV] = ALUFlags[FlagC:FlagV];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_flags <= 4'b0000;
    else       r_flags <= w_flags_d;
  end

  // A stalled E instruction must not reach M1 until it is released.
  always_comb begin
    w_m1_in = '0;
    if (!StallE) begin
      w_m1_in.reg_write  = r_reg_write_e & w_cond_ex;
      w_m1_in.mem_write  = r_mem_write_e & w_cond_ex;
      w_m1_in.pc_src     = r_pc_src_e & w_cond_ex;
      w_m1_in.mem_to_reg = r_mem_to_reg_e;
    end
  end

  // Stage 0 (M1) lives in the low slot; older stages shift upward.
  assign w_shift = {r_m_chain, w_m1_in};

  always_ff @(posedge clk) begin
    if (reset) r_m_chain <= '0;
    else       r_m_chain <= w_shift[ChainW-1:0];
  end

  assign w_m_first = r_m_chain[MStageW-1:0];
  assign w_m_last  = r_m_chain[ChainW-MStageW +: MStageW];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write_w  <= 1'b0;
      r_mem_to_reg_w <= 1'b0;
      r_pc_src_w     <= 1'b0;
    end else begin
      r_reg_write_w  <= w_m_last.reg_write;
      r_mem_to_reg_w <= w_m_last.mem_to_reg;
      r_pc_src_w     <= w_m_last.pc_src;
    end
  end

  assign ALUSrcE      = r_alu_src_e;
  assign ALUControlE  = r_alu_control_e;
  assign MemtoRegE    = r_mem_to_reg_e;
  assign PCSrcE       = r_pc_src_e;
  assign CondExE      = w_cond_ex;
  assign BranchTakenE = r_branch_e & w_cond_ex;
  assign MemWriteM    = w_m_first.mem_write;
  assign RegWriteM    = w_m_last.reg_write;
  assign PCSrcM       = w_m_last.pc_src;
  assign MemtoRegM    = w_m_last.mem_to_reg;
  assign RegWriteW    = r_reg_write_w;
  assign MemtoRegW    = r_mem_to_reg_w;
  assign PCSrcW       = r_pc_src_w;
  assign Flags        = r_flags;

endmodule
